s_mem_arbiter: RTL and testbench

Arbiter and access sequencer for the shared 256x8 RC4 working memory (S array). Three task engines compete for it: S-init (task 1), KSA swap (task 2a) and PRGA decrypt (task 2b). A requester locks the memory for multi-cycle read-modify-write sequences, such as the i/j swap. The block sits between those engines and the single-port RAM, and key-search restarts reuse it unchanged.

---
 rtl/s_mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_s_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter
//
// Arbiter and access sequencer for the shared 256x8 RC4 S-array RAM. Three task
// engines (0 = S-init, 1 = KSA swap, 2 = PRGA decrypt) compete for one
// single-port RAM. A requester holds the RAM for as long as its req stays high,
// so multi-cycle read-modify-write sequences such as the i/j swap are never
// interleaved with another engine's accesses.
//
// Optional build macro: S_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest index wins (0 > 1 > 2)
//   undefined -> round-robin, searching upward from last_owner + 1
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req       [N_REQ]     per-requester lock request (level)
//   cmd_valid [N_REQ]     per-requester access strobe, one access per cycle
//   req_addr  [N_REQ*AW]  packed addresses, requester r at [r*AW +: AW]
//   req_wdata [N_REQ*DW]  packed write data
//   req_wren  [N_REQ]     1 = write, 0 = read
//   gnt       [N_REQ]     one-hot grant (registered)
//   owner     [2]         current owner index, valid while busy
//   busy                  high from grant through drain
//   mem_addr/mem_wdata/mem_wren   registered RAM bus
//   mem_q                 RAM read data
//   rd_data               mem_q passed through
//   rd_valid  [N_REQ]     one-hot read-return strobe to the owner
//
// RD_LAT (1..3) is the RAM latency from address sampled to mem_q valid.

module s_mem_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    cmd_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  input  logic [N_REQ-1:0]    req_wren,
  output logic [N_REQ-1:0]    gnt,
  output logic [1:0]          owner,
  output logic                busy,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_wren,
  input  logic [DW-1:0]       mem_q,
  output logic [DW-1:0]       rd_data,
  output logic [N_REQ-1:0]    rd_valid
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOwn   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Read-tag pipe depth; rd_valid is one more register after the last stage so
  // the strobe lines up with mem_q one cycle after the RAM's output stage.
  localparam int PIPE_D = int'(RD_LAT) + 1;
  localparam int TAG_W  = PIPE_D * int'(N_REQ);

  localparam logic [N_REQ-1:0] ReqOne = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_owner_q, last_owner_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic               mem_wren_q, mem_wren_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [N_REQ-1:0]   rd_valid_q;

  logic [1:0]         pick;
  logic [N_REQ-1:0]   own_sel;
  logic               own_req;
  logic               own_cmd;
  logic               own_wren;
  logic [AW-1:0]      own_addr;
  logic [DW-1:0]      own_wdata;
  logic               push_rd;
  logic               pipe_empty;

  // ---------------------------------------------------------------------------
  // Winner selection (only consulted in StIdle)
  // ---------------------------------------------------------------------------
`ifdef S_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = 2'd0;
    // Descending scan so the lowest requesting index is the last to assign.
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if ((req & (ReqOne << i)) != '0) begin
        pick = 2'(i);
      end
    end
  end
`else
  always_comb begin
    logic        found;
    int unsigned idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 0;
    // Search upward from last_owner + 1, wrapping, so the previous owner is
    // considered last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_owner_q) + k) % N_REQ;
      if (!found && ((req & (ReqOne << idx)) != '0)) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Owner-side view of the request bus
  // ---------------------------------------------------------------------------
  assign own_sel  = ReqOne << owner_q;
  assign own_req  = (req & own_sel) != '0;
  assign own_cmd  = (cmd_valid & own_sel) != '0;
  assign own_wren = (req_wren & own_sel) != '0;

  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    for (int r = 0; r < int'(N_REQ); r++) begin
      if (owner_q == 2'(r)) begin
        own_addr  = AW'(req_addr >> (r * int'(AW)));
        own_wdata = DW'(req_wdata >> (r * int'(DW)));
      end
    end
  end

  assign pipe_empty = (tag_q == '0);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wren_d   = 1'b0;
    push_rd      = 1'b0;

    case (state_q)
      StIdle: begin
        if (req != '0) begin
          state_d = StOwn;
          owner_d = pick;
          gnt_d   = ReqOne << pick;
          busy_d  = 1'b1;
        end
      end
      StOwn: begin
        // Release takes precedence: a strobe in the release cycle is dropped.
        if (!own_req) begin
          state_d = StDrain;
        end else if (own_cmd) begin
          mem_addr_d  = own_addr;
          mem_wdata_d = own_wdata;
          mem_wren_d  = own_wren;
          push_rd     = !own_wren;
        end
      end
      StDrain: begin
        if (pipe_empty) begin
          state_d      = StIdle;
          gnt_d        = '0;
          busy_d       = 1'b0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // New tag enters at the bottom; the oldest leaves at the top into rd_valid.
  assign tag_d = {tag_q[TAG_W-int'(N_REQ)-1:0], (push_rd ? own_sel : {N_REQ{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      owner_q      <= 2'd0;
      busy_q       <= 1'b0;
      last_owner_q <= 2'(N_REQ - 1);
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
      tag_q        <= '0;
      rd_valid_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wren_q   <= mem_wren_d;
      tag_q        <= tag_d;
      rd_valid_q   <= tag_q[TAG_W-1 -: N_REQ];
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign rd_data   = mem_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
module tb_s_mem_arbiter;

  localparam int N_REQ = 3;
  localparam int AW    = 8;
  localparam int DW    = 8;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    cmd_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_wren;
  logic [N_REQ-1:0]    gnt;
  logic [1:0]          owner;
  logic                busy;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_wren;
  logic [DW-1:0]       mem_q;
  logic [DW-1:0]       rd_data;
  logic [N_REQ-1:0]    rd_valid;

  s_mem_arbiter #(
    .N_REQ  (N_REQ),
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cmd_valid (cmd_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wren  (req_wren),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address register at the sampling edge, output register one
  // edge later (RD_LAT = 1).
  logic [7:0] ram [256];
  logic [7:0] addr_r;
  logic [7:0] q_r;
  logic       preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5F;
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    addr_r <= mem_addr;
    q_r    <= ram[addr_r];
  end
  assign mem_q = q_r;

  // Bench reference memory and scoreboard
  typedef struct packed {
    logic [2:0] tag;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t    sb_q[$];
  logic [7:0] gold [256];
  logic [7:0] exp_addr;
  int         exp_writes;
  int         wr_seen;
  int         n_checks;
  int         n_errs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read-return monitor, sampled on the falling edge.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n) begin
      if (mem_wren) wr_seen++;
      if (rd_valid != '0) begin
        if (sb_q.size() == 0) begin
          check_eq("rd_unexpected", 32'(rd_valid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq("rd_tag", 32'(rd_valid), 32'(e.tag));
          check_eq("rd_data", 32'(rd_data), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int r, input logic [7:0] a, input logic [7:0] d,
                           input logic w);
    cmd_valid = 3'b001 << r;
    req_addr  = {16'b0, a} << (r * 8);
    req_wdata = {16'b0, d} << (r * 8);
    req_wren  = w ? (3'b001 << r) : 3'b000;
  endtask

  // Accepted access by the owner: book-keep, issue, check the bus.
  task automatic acc(input int r, input logic [7:0] a, input logic [7:0] d, input logic w);
    rd_exp_t e;
    if (w) begin
      gold[a] = d;
      exp_writes++;
    end else begin
      e.tag  = 3'b001 << r;
      e.data = gold[a];
      sb_q.push_back(e);
    end
    exp_addr = a;
    drive_cmd(r, a, d, w);
    tick();
    cmd_valid = '0;
    check_eq("bus_addr", 32'(mem_addr), 32'(a));
    check_eq("bus_wren", 32'(mem_wren), 32'(w));
    if (w) check_eq("bus_wdata", 32'(mem_wdata), 32'(d));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy) break;
    end
    check_eq("idle", 32'({busy, gnt}), 32'(0));
  endtask

  logic [7:0] v10, v20;
  logic [2:0] exp_ord [4];
  logic [2:0] rdv_or;
  int         wr0;
  int         zeros;

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req = '0; cmd_valid = '0; req_addr = '0; req_wdata = '0; req_wren = '0;
    n_checks = 0; n_errs = 0; exp_writes = 0; wr_seen = 0; exp_addr = 8'h00;
    for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'h5F;

    // Reset then single request
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'(0));
    check_eq("rst_owner", 32'(owner), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_wren", 32'(mem_wren), 32'(0));
    check_eq("rst_rdv", 32'(rd_valid), 32'(0));
    preload = 1'b0;
    rst_n   = 1'b1;
    req     = 3'b001;
    tick();
    check_eq("gnt_first", 32'(gnt), 32'(3'b001));
    check_eq("busy_first", 32'(busy), 32'(1));
    check_eq("owner_first", 32'(owner), 32'(0));

    // Read latency
    acc(0, 8'h05, 8'h00, 1'b0);
    tick();
    check_eq("rd_early", 32'(rd_valid), 32'(0));
    tick();
    check_eq("rd_lat_valid", 32'(rd_valid), 32'(3'b001));
    check_eq("rd_lat_data", 32'(rd_data), 32'(8'h5A));
    tick();
    check_eq("rd_once", 32'(rd_valid), 32'(0));
    req = '0;
    wait_idle();

    // Swap sequence by owner 1
    req = 3'b010;
    tick();
    check_eq("gnt_swap", 32'(gnt), 32'(3'b010));
    check_eq("owner_swap", 32'(owner), 32'(1));
    v10 = gold[8'h10];
    v20 = gold[8'h20];
    wr0 = wr_seen;
    acc(1, 8'h10, 8'h00, 1'b0);
    acc(1, 8'h20, 8'h00, 1'b0);
    acc(1, 8'h10, v20, 1'b1);
    acc(1, 8'h20, v10, 1'b1);
    acc(1, 8'h10, 8'h00, 1'b0);
    acc(1, 8'h20, 8'h00, 1'b0);
    repeat (3) tick();
    check_eq("swap_wr_pulses", 32'(wr_seen - wr0), 32'(2));
    req = '0;
    wait_idle();

    // Reset mid-read
    req = 3'b100;
    tick();
    check_eq("gnt_r2", 32'(gnt), 32'(3'b100));
    acc(2, 8'h07, 8'h00, 1'b0);
    drive_cmd(2, 8'h08, 8'hAA, 1'b1);
    tick();
    cmd_valid = '0;
    check_eq("wren_pre_rst", 32'(mem_wren), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("wren_async", 32'(mem_wren), 32'(0));
    check_eq("gnt_async", 32'(gnt), 32'(0));
    sb_q.delete();
    exp_addr = 8'h00;
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    rdv_or = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rdv_or = rdv_or | rd_valid;
    end
    check_eq("no_rdv_after_rst", 32'(rdv_or), 32'(0));
    req = 3'b101;
    tick();
    check_eq("gnt_post_rst", 32'(gnt), 32'(3'b001));
    req = '0;
    wait_idle();

    // Contention: fresh reset so the pointer starts at N_REQ-1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef S_ARB_FIXED_PRIO_EN
    exp_ord[0] = 3'b001; exp_ord[1] = 3'b001; exp_ord[2] = 3'b001; exp_ord[3] = 3'b001;
`else
    exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100; exp_ord[3] = 3'b001;
`endif
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      zeros = 0;
      for (int i = 0; i < 10; i++) begin
        if (gnt != '0) break;
        zeros++;
        tick();
      end
      check_eq("cont_gnt", 32'(gnt), 32'(exp_ord[g]));
      if (g > 0) check_eq("cont_dead_cycle", 32'(zeros), 32'(1));
      if (g < 3) begin
        repeat (4) tick();
        req = 3'b111 & ~gnt;
        tick();
        req = 3'b111;
        tick();
      end
    end

    // Non-owner strobe while owner 0 holds the RAM
    drive_cmd(2, 8'hEE, 8'h11, 1'b1);
    tick();
    cmd_valid = '0;
    check_eq("nonown_wren", 32'(mem_wren), 32'(0));
    check_eq("nonown_addr", 32'(mem_addr), 32'(exp_addr));

    // Release with a strobe and a read outstanding
    acc(0, 8'h33, 8'h00, 1'b0);
    req = 3'b110;
    drive_cmd(0, 8'h44, 8'h99, 1'b1);
    tick();
    cmd_valid = '0;
    check_eq("rel_wren", 32'(mem_wren), 32'(0));
    check_eq("rel_addr", 32'(mem_addr), 32'(8'h33));
    check_eq("rel_drain_gnt", 32'(gnt), 32'(3'b001));
    tick();
    check_eq("rel_rdv", 32'(rd_valid), 32'(3'b001));
    check_eq("rel_busy", 32'(busy), 32'(1));
    tick();
    check_eq("rel_gnt_off", 32'(gnt), 32'(0));
    tick();
    check_eq("rel_next_gnt", 32'(gnt), 32'(3'b010));
    req = '0;
    wait_idle();

    repeat (4) tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
    check_eq("wr_total", 32'(wr_seen), 32'(exp_writes));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
